dice_sampler: RTL and testbench

DICE_SAMPLER -- requirements
Module: dice_sampler

---
 rtl/dice_sampler.sv | 207 ++++++++++++++++++++
 tb/tb_dice_sampler.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dice_sampler.sv
// rtl/dice_sampler.sv - electronic die: debiased ring-oscillator bits to faces 1..SIDES
//
// Purpose:
//   Samples a raw entropy bit every SAMPLE_DIV clocks, removes bias with a
//   von Neumann pair debiaser, collects three debiased bits into v (MSB first)
//   and rejects v >= SIDES, so every accepted roll is uniform over 1..SIDES.
//   The result is held on roll_value/out_valid until the consumer takes it.
//
// Optional feature (macro DICE_HEALTH_EN):
//   Repetition-count health test on the strobed raw samples. REP_LIMIT equal
//   samples in a row set a sticky fault that aborts collection and blocks new
//   rolls until reset. Without the macro there is no health logic and fault=0.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high reset
//   rnd_bit    in   synchronised raw bit from the entropy source
//   roll_req   in   single-cycle request for one roll (honoured in IDLE only)
//   out_ready  in   consumer accepts roll_value (honoured in HOLD only)
//   roll_value out  face 1..SIDES, keeps its last value after hand-off
//   out_valid  out  roll_value is valid (HOLD)
//   busy       out  a roll is in progress (COLLECT, CHECK or HOLD)
//   fault      out  sticky entropy-health failure

module dice_sampler #(
  parameter int SAMPLE_DIV = 4,
  parameter int SIDES      = 6,
  parameter int REP_LIMIT  = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rnd_bit,
  input  logic       roll_req,
  input  logic       out_ready,
  output logic [2:0] roll_value,
  output logic       out_valid,
  output logic       busy,
  output logic       fault
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    CHECK   = 2'd2,
    HOLD    = 2'd3
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(SAMPLE_DIV - 1);
  localparam logic [3:0] SIDES_W  = 4'(SIDES);

  state_t     state;
  state_t     state_nxt;

  logic [7:0] div_cnt;
  logic       strobe;

  logic       pair_phase;
  logic       pair_first;
  logic       deb_valid;
  logic       enter_collect;

  logic [2:0] acc;
  logic [1:0] bit_cnt;
  logic       accept;
  logic       load_roll;

  // Free-running sample divider; with SAMPLE_DIV=1 the count stays at 0 and
  // the strobe is permanently high.
  assign strobe = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (strobe) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 8'd1;
    end
  end

  // Pair phase and accumulator restart on every entry to COLLECT, both from
  // IDLE and after a rejected value, so a stale half-pair never leaks in.
  assign enter_collect = (state_nxt == COLLECT) && (state != COLLECT);

  // Second sample of a pair that differs from the first yields the first
  // sample as the debiased bit (10 -> 1, 01 -> 0).
  assign deb_valid = (state == COLLECT) && strobe && pair_phase && (pair_first != rnd_bit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pair_phase <= 1'b0;
      pair_first <= 1'b0;
    end else if (enter_collect) begin
      pair_phase <= 1'b0;
    end else if ((state == COLLECT) && strobe) begin
      pair_phase <= ~pair_phase;
      if (!pair_phase) begin
        pair_first <= rnd_bit;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc     <= '0;
      bit_cnt <= '0;
    end else if (enter_collect) begin
      acc     <= '0;
      bit_cnt <= '0;
    end else if (deb_valid) begin
      acc     <= {acc[1:0], pair_first};
      bit_cnt <= bit_cnt + 2'd1;
    end
  end

  // Compared in 4 bits so SIDES=8 accepts every 3-bit value.
  assign accept    = ({1'b0, acc} < SIDES_W);
  assign load_roll = (state == CHECK) && !fault && accept;

`ifdef DICE_HEALTH_EN
  logic       last_sample;
  logic [7:0] rep_cnt;
  logic       fault_r;

  // rep_cnt is 0 only straight after reset, so the first sample starts a
  // run of length 1 regardless of last_sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_sample <= 1'b0;
      rep_cnt     <= '0;
      fault_r     <= 1'b0;
    end else begin
      if (strobe) begin
        last_sample <= rnd_bit;
        if ((rep_cnt != 8'd0) && (rnd_bit == last_sample)) begin
          if (rep_cnt != 8'hFF) begin
            rep_cnt <= rep_cnt + 8'd1;
          end
        end else begin
          rep_cnt <= 8'd1;
        end
      end
      if (rep_cnt >= 8'(REP_LIMIT)) begin
        fault_r <= 1'b1;
      end
    end
  end

  assign fault = fault_r;
`else
  assign fault = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (roll_req && !fault) begin
          state_nxt = COLLECT;
        end
      end
      COLLECT: begin
        if (fault) begin
          state_nxt = IDLE;
        end else if (deb_valid && (bit_cnt == 2'd2)) begin
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        if (fault) begin
          state_nxt = IDLE;
        end else if (accept) begin
          state_nxt = HOLD;
        end else begin
          state_nxt = COLLECT;
        end
      end
      HOLD: begin
        // A roll already accepted finishes its hand-off even under fault.
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      roll_value <= '0;
    end else if (load_roll) begin
      roll_value <= acc + 3'd1;
    end
  end

  assign out_valid = (state == HOLD);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_dice_sampler.sv
// tb/tb_dice_sampler.sv - scoreboard bench for dice_sampler
module tb_dice_sampler;

  localparam int SIDES = 6;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, rnd_bit, roll_req, out_ready;
  logic [2:0] roll_value;
  logic       out_valid, busy, fault;

  logic       rst4, rnd4, req4, rdy4;
  logic [2:0] val4;
  logic       valid4, busy4, fault4;

  dice_sampler #(.SAMPLE_DIV(1), .SIDES(SIDES), .REP_LIMIT(32)) dut (
    .clk(clk), .reset(rst), .rnd_bit(rnd_bit), .roll_req(roll_req), .out_ready(out_ready),
    .roll_value(roll_value), .out_valid(out_valid), .busy(busy), .fault(fault)
  );

  dice_sampler #(.SAMPLE_DIV(4), .SIDES(SIDES), .REP_LIMIT(32)) dut4 (
    .clk(clk), .reset(rst4), .rnd_bit(rnd4), .roll_req(req4), .out_ready(rdy4),
    .roll_value(val4), .out_valid(valid4), .busy(busy4), .fault(fault4)
  );

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  int hs_count = 0;
  bit cur_seq[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Reference: walk the strobed samples of one roll in pairs, keep the first
  // sample of unequal pairs, build v MSB first; after three bits accept v < SIDES
  // as face v+1 (3-bit), otherwise drop v and the one sample seen during the
  // check cycle, then start over. Returns 0 when the list yields no face.
  function automatic int model_roll();
    int bits = 0;
    int v = 0;
    int i = 0;
    while (i + 1 < cur_seq.size()) begin
      if (cur_seq[i] != cur_seq[i+1]) begin
        v = (v * 2 + int'(cur_seq[i])) % 8;
        bits++;
      end
      i += 2;
      if (bits == 3) begin
        if (v < SIDES) return (v + 1) % 8;
        i += 1;
        bits = 0;
        v = 0;
      end
    end
    return 0;
  endfunction

  task automatic load_seq(input logic [63:0] bits, input int n);
    cur_seq.delete();
    for (int i = 0; i < n; i++) cur_seq.push_back(bits[n-1-i]);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic feed_roll(input bit rand_req);
    int e;
    e = model_roll();
    if (e != 0) exp_q.push_back(e);
    roll_req  = 1'b1;
    out_ready = 1'b0;
    rnd_bit   = 1'($urandom_range(0, 1));
    tick();
    foreach (cur_seq[i]) begin
      rnd_bit  = cur_seq[i];
      roll_req = rand_req ? ($urandom_range(0, 3) == 0) : 1'b0;
      tick();
    end
    roll_req = 1'b0;
  endtask

  task automatic finish_roll();
    int start;
    int n;
    start = hs_count;
    n = 0;
    while (hs_count == start && n < 200) begin
      out_ready = ($urandom_range(0, 2) == 0);
      roll_req  = ($urandom_range(0, 3) == 0);
      rnd_bit   = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    roll_req  = 1'b0;
    out_ready = 1'b0;
    check("handshake_seen", hs_count - start, 1);
    repeat (3) tick();
  endtask

  // Monitor: compares every presented result against the scoreboard and
  // checks HOLD stability and the drop of out_valid after acceptance.
  bit         prev_hold = 1'b0;
  bit         prev_hs   = 1'b0;
  logic [2:0] prev_val  = '0;

  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
      prev_hs   = 1'b0;
      exp_q.delete();
    end else begin
      if (prev_hold) begin
        check("hold_valid_stable", out_valid, 1);
        check("hold_value_stable", roll_value, prev_val);
      end
      if (prev_hs) check("valid_drop_after_accept", out_valid, 0);
      if (out_valid) begin
        check("busy_in_hold", busy, 1);
        check("fault_clear", fault, 0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got out_valid=1 roll_value=%0d, required no result", roll_value);
        end else begin
          check("roll_value", roll_value, exp_q[0]);
          if (out_ready) begin
            void'(exp_q.pop_front());
            hs_count++;
          end
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_hs   = out_valid && out_ready;
      prev_val  = roll_value;
    end
  end

  // SAMPLE_DIV=4 die: only strobes on the 4th, 8th, ... edge after reset
  // release should be used; the other cycles carry the complement.
  task automatic dut4_phase_roll(input bit stop_in_check);
    logic [5:0] sv;
    int j;
    sv = 6'b100101;
    for (int k = 1; k <= 25; k++) begin
      j = (k - 1) / 4;
      if (j > 5) j = 5;
      req4 = (k == 1);
      rnd4 = (k % 4 == 0) ? sv[5-j] : ~sv[5-j];
      tick();
      if (k == 24) begin
        check("div4_no_early_valid", valid4, 0);
        check("div4_busy_in_check", busy4, 1);
        if (stop_in_check) begin
          rst4 = 1'b1;
          #1;
          check("div4_rst_value", val4, 0);
          check("div4_rst_valid", valid4, 0);
          check("div4_rst_busy", busy4, 0);
          check("div4_rst_fault", fault4, 0);
          return;
        end
      end
    end
    req4 = 1'b0;
    check("div4_valid_after_check", valid4, 1);
    check("div4_value", val4, 5);
  endtask

  initial begin
    int e;
    rst = 1'b1; rnd_bit = 1'b0; roll_req = 1'b0; out_ready = 1'b0;
    rst4 = 1'b1; rnd4 = 1'b0; req4 = 1'b0; rdy4 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_roll_value", roll_value, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_fault", fault, 0);
    rst = 1'b0;
    tick();

    // 10,01,01 -> v=100 -> face 5, held with out_ready low
    load_seq(64'b100101, 6);
    feed_roll(1'b0);
    repeat (5) tick();
    finish_roll();

    // v=6 rejected, one sample lost in CHECK, then 01,10,01 -> face 3
    load_seq(64'b1010010011001, 13);
    feed_roll(1'b0);
    finish_roll();

    // v=7 rejected, then 01,01,01 -> face 1
    load_seq(64'b1010100010101, 13);
    feed_roll(1'b0);
    finish_roll();

    // equal pairs discarded, stray roll_req pulses ignored -> face 5
    load_seq(64'b111000011101, 12);
    feed_roll(1'b1);
    finish_roll();

    // largest face: 10,01,10 -> v=5 -> face 6
    load_seq(64'b100110, 6);
    feed_roll(1'b0);
    finish_roll();

    for (int r = 0; r < 25; r++) begin
      do begin
        cur_seq.delete();
        for (int i = 0; i < 24; i++) cur_seq.push_back(1'($urandom_range(0, 1)));
        e = model_roll();
      end while (e == 0);
      feed_roll(1'b1);
      finish_roll();
    end

    // reset in COLLECT abandons the roll and clears the retained value
    roll_req = 1'b1; tick(); roll_req = 1'b0;
    rnd_bit = 1'b1; tick();
    rnd_bit = 1'b0; tick();
    rnd_bit = 1'b0; tick();
    rst = 1'b1;
    #1;
    check("rst_collect_value", roll_value, 0);
    check("rst_collect_busy", busy, 0);
    tick();
    rst = 1'b0;
    repeat (8) tick();
    check("idle_after_rst_busy", busy, 0);

    // reset in HOLD drops out_valid at once
    load_seq(64'b011010, 6);
    feed_roll(1'b0);
    repeat (2) tick();
    check("hold_before_rst", out_valid, 1);
    rst = 1'b1;
    #1;
    check("rst_hold_valid", out_valid, 0);
    check("rst_hold_value", roll_value, 0);
    tick();
    rst = 1'b0;
    repeat (3) tick();

    // SAMPLE_DIV=4: reset during CHECK, then strobe phase after release
    rst4 = 1'b0;
    dut4_phase_roll(1'b1);
    tick();
    rst4 = 1'b0;
    dut4_phase_roll(1'b0);
    rdy4 = 1'b1; tick(); rdy4 = 1'b0;
    check("div4_valid_drop", valid4, 0);
    check("div4_value_retained", val4, 5);
    tick();

`ifdef DICE_HEALTH_EN
    roll_req = 1'b1; rnd_bit = 1'b1; tick(); roll_req = 1'b0;
    repeat (40) tick();
    check("health_fault_set", fault, 1);
    check("health_idle", busy, 0);
    roll_req = 1'b1; tick(); roll_req = 1'b0; tick();
    check("health_req_ignored", busy, 0);
    rst = 1'b1;
    #1;
    check("health_fault_cleared", fault, 0);
    tick();
    rst = 1'b0;
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
